// File: rtl/serial_arith_pkg.sv
// Shared types and defaults for the bit-serial arithmetic blocks.
package serial_arith_pkg;

  localparam int unsigned SUB_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

endpackage

// File: rtl/full_subtractor_cell.sv
// Single-bit full subtractor: d = a - b - bi, with borrow-out bo.
module full_subtractor_cell (
  output logic d,
  output logic bo,
  input  logic a,
  input  logic b,
  input  logic bi
);

  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, LSB first through one full-subtractor cell.
//
// state | meaning
// IDLE  | ready for operands, no result held
// SHIFT | one difference bit per cycle, counter tracks bit index
// DONE  | result held until out_ready
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  sub_state_t       state_q;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, res_q;
  logic [CNT_W-1:0] cnt_q;
  logic             br_q;
  logic             a_msb_q, b_msb_q;
  logic             borrow_q, ovf_q;
  logic             in_ready_q, out_valid_q;

  logic             cell_d, cell_bo;
  logic [WIDTH-1:0] a_sr_d, b_sr_d, res_d;
  logic [CNT_W-1:0] cnt_d;
  logic             ovf_d;

  full_subtractor_cell u_cell (
    .d  (cell_d),
    .bo (cell_bo),
    .a  (a_sr_q[0]),
    .b  (b_sr_q[0]),
    .bi (br_q)
  );

  assign a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
  assign b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
  assign res_d  = {cell_d, res_q[WIDTH-1:1]};
  assign cnt_d  = cnt_q + 1'b1;
  // On the last bit cell_d is the result MSB, so overflow is known this cycle.
  assign ovf_d  = (a_msb_q != b_msb_q) && (cell_d != a_msb_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      br_q        <= 1'b0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      borrow_q    <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sr_q     <= a;
            b_sr_q     <= b;
            br_q       <= 1'b0;
            cnt_q      <= '0;
            a_msb_q    <= a[WIDTH-1];
            b_msb_q    <= b[WIDTH-1];
            in_ready_q <= 1'b0;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr_q <= a_sr_d;
          b_sr_q <= b_sr_d;
          res_q  <= res_d;
          br_q   <= cell_bo;
          cnt_q  <= cnt_d;
          if (cnt_q == LAST_BIT) begin
            borrow_q    <= cell_bo;
            ovf_q       <= ovf_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign diff       = res_q;
  assign borrow_out = borrow_q;
  assign ovf        = ovf_q;

  a_no_overlap: assert property (@(posedge clk) disable iff (rst) !(in_ready_q && out_valid_q));

  a_hold_done: assert property (@(posedge clk) disable iff (rst)
    (out_valid_q && !out_ready) |=> (out_valid_q && $stable(res_q) && $stable(borrow_q) && $stable(ovf_q)));

endmodule
